// File: rtl/seq_counter.sv
// Parametrised sequence counter: binary index with up/down stepping, synchronous
// load, and binary or Gray presentation selected by a registered mode.
module seq_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Compares are made one bit wider so MODULUS = 2^WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_IDX = MAX_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] r_idx;
  logic [1:0]       r_mode;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH:0]   w_idx_ext;
  logic [WIDTH:0]   w_load_ext;
  logic             w_load_ok;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_idx_up;
  logic [WIDTH-1:0] w_idx_down;
  logic [WIDTH-1:0] w_gray;

  assign w_idx_ext  = {1'b0, r_idx};
  assign w_load_ext = {1'b0, load_val};
  assign w_load_ok  = (w_load_ext < MOD_EXT);
  assign w_at_max   = (w_idx_ext == MAX_EXT);
  assign w_at_zero  = (r_idx == '0);

  assign w_idx_up   = w_at_max  ? '0      : r_idx + WIDTH'(1);
  assign w_idx_down = w_at_zero ? MAX_IDX : r_idx - WIDTH'(1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign w_gray[gi] = r_idx[gi] ^ r_idx[gi+1];
    end
  endgenerate
  assign w_gray[WIDTH-1] = r_idx[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_mode     <= 2'b00;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_mode <= mode;
      if (load) begin
        r_idx      <= w_load_ok ? load_val : '0;
        r_load_err <= ~w_load_ok;
        r_wrap     <= 1'b0;
      end else if (en) begin
        // Direction comes from the live mode input so a reversal acts this edge.
        if (mode[0]) begin
          r_idx  <= w_idx_down;
          r_wrap <= w_at_zero;
        end else begin
          r_idx  <= w_idx_up;
          r_wrap <= w_at_max;
        end
        r_load_err <= 1'b0;
      end else begin
        r_wrap     <= 1'b0;
        r_load_err <= 1'b0;
      end
    end
  end

  assign q        = r_mode[1] ? w_gray : r_idx;
  assign tc       = en & ((~r_mode[0] & w_at_max) | (r_mode[0] & w_at_zero));
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_seq_counter.sv
// Bench for seq_counter: a 16-state and a 10-state instance share stimulus and are
// checked every cycle against a behavioural model plus literal expectations.
module tb_seq_counter;

  localparam int W = 4;
  localparam int MODS [2] = '{16, 10};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] q_a [2];
  logic         tc_a [2];
  logic         wrap_a [2];
  logic         lerr_a [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_counter #(.WIDTH(W), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .q(q_a[0]), .tc(tc_a[0]), .wrap(wrap_a[0]), .load_err(lerr_a[0])
  );

  seq_counter #(.WIDTH(W), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .q(q_a[1]), .tc(tc_a[1]), .wrap(wrap_a[1]), .load_err(lerr_a[1])
  );

  // Behavioural model: integer index and flags, arithmetic modulo the count length.
  int m_idx [2];
  int m_mode [2];
  int m_wrap [2];
  int m_lerr [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_mode[k] = 0; m_wrap[k] = 0; m_lerr[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_idx[k] <= 0; m_mode[k] <= 0; m_wrap[k] <= 0; m_lerr[k] <= 0;
      end else begin
        m_mode[k] <= int'(mode);
        if (load) begin
          m_wrap[k] <= 0;
          if (int'(load_val) < MODS[k]) begin
            m_idx[k] <= int'(load_val); m_lerr[k] <= 0;
          end else begin
            m_idx[k] <= 0; m_lerr[k] <= 1;
          end
        end else if (en) begin
          m_lerr[k] <= 0;
          if (mode[0] == 1'b0) begin
            m_wrap[k] <= (m_idx[k] == MODS[k] - 1) ? 1 : 0;
            m_idx[k]  <= (m_idx[k] + 1) % MODS[k];
          end else begin
            m_wrap[k] <= (m_idx[k] == 0) ? 1 : 0;
            m_idx[k]  <= (m_idx[k] + MODS[k] - 1) % MODS[k];
          end
        end else begin
          m_wrap[k] <= 0; m_lerr[k] <= 0;
        end
      end
    end
  end

  function automatic int exp_q(int k);
    if ((m_mode[k] & 2) != 0) return m_idx[k] ^ (m_idx[k] >> 1);
    return m_idx[k];
  endfunction

  function automatic int exp_tc(int k);
    int at_end;
    at_end = ((m_mode[k] & 1) == 0) ? int'(m_idx[k] == MODS[k] - 1) : int'(m_idx[k] == 0);
    return (en && at_end != 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("model_q[m%0d]", MODS[k]),    int'(q_a[k]),    exp_q(k));
        check($sformatf("model_tc[m%0d]", MODS[k]),   int'(tc_a[k]),   exp_tc(k));
        check($sformatf("model_wrap[m%0d]", MODS[k]), int'(wrap_a[k]), m_wrap[k]);
        check($sformatf("model_lerr[m%0d]", MODS[k]), int'(lerr_a[k]), m_lerr[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  logic [W-1:0] prev_q;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_q16", int'(q_a[0]), 0);
    check("rst_q10", int'(q_a[1]), 0);
    check("rst_wrap", int'(wrap_a[0]), 0);
    check("rst_lerr", int'(lerr_a[0]), 0);
    $display("[TB] reset done");

    // Binary up count through the full 16-state cycle.
    mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("up_q15", int'(q_a[0]), 15);
    check("up_tc15", int'(tc_a[0]), 1);
    check("up_wrap_before", int'(wrap_a[0]), 0);
    tick();
    check("up_wrap_q0", int'(q_a[0]), 0);
    check("up_wrap_pulse", int'(wrap_a[0]), 1);
    tick();
    check("up_q1", int'(q_a[0]), 1);
    check("up_wrap_clear", int'(wrap_a[0]), 0);
    $display("[TB] binary up count done");

    // Gray up count: every transition flips exactly one bit.
    do_reset();
    mode = 2'b10; en = 1'b1;
    prev_q = q_a[0];
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("gray_onebit_%0d", i), $countones(prev_q ^ q_a[0]), 1);
      if (i == 3) check("gray_q3", int'(q_a[0]), 4'b0010);
      if (i == 8) check("gray_q8", int'(q_a[0]), 4'b1100);
      prev_q = q_a[0];
    end
    check("gray_final", int'(q_a[0]), 0);
    $display("[TB] gray up count done");

    // Down count from reset wraps immediately.
    do_reset();
    mode = 2'b01; en = 1'b1;
    tick();
    check("down_q15", int'(q_a[0]), 15);
    check("down_q9_m10", int'(q_a[1]), 9);
    check("down_wrap", int'(wrap_a[0]), 1);
    tick();
    check("down_q14", int'(q_a[0]), 14);
    $display("[TB] down count done");

    // Load with simultaneous enable, then count over the modulo-10 boundary.
    do_reset();
    mode = 2'b00; en = 1'b1; load = 1'b1; load_val = 4'd8;
    tick();
    check("load_wins_q", int'(q_a[1]), 8);
    load = 1'b0;
    tick();
    check("load_up_q9", int'(q_a[1]), 9);
    tick();
    check("m10_wrap_q0", int'(q_a[1]), 0);
    check("m10_wrap_pulse", int'(wrap_a[1]), 1);
    check("m16_q10", int'(q_a[0]), 10);
    tick();
    check("m10_q1", int'(q_a[1]), 1);
    $display("[TB] load and modulo-10 wrap done");

    // Out-of-range load and boundary values.
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick();
    check("bad_load_q", int'(q_a[1]), 0);
    check("bad_load_err", int'(lerr_a[1]), 1);
    check("ok_load_m16", int'(q_a[0]), 12);
    load_val = 4'd10;
    tick();
    check("load_eq_mod_err", int'(lerr_a[1]), 1);
    load_val = 4'd9;
    tick();
    check("load_max_ok", int'(lerr_a[1]), 0);
    check("load_max_q", int'(q_a[1]), 9);
    load = 1'b0;
    tick();
    check("lerr_clear", int'(lerr_a[1]), 0);
    $display("[TB] load range checks done");

    // Reset wins over load and enable.
    load = 1'b1; load_val = 4'd7;
    tick();
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd3;
    tick();
    check("rst_wins_q", int'(q_a[0]), 0);
    check("rst_wins_wrap", int'(wrap_a[0]), 0);
    check("rst_wins_lerr", int'(lerr_a[1]), 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    $display("[TB] reset priority done");

    // Encoding change while holding.
    load = 1'b1; load_val = 4'd5; mode = 2'b00;
    tick();
    check("hold_bin5", int'(q_a[0]), 4'b0101);
    load = 1'b0; en = 1'b0; mode = 2'b10;
    tick();
    check("hold_gray5", int'(q_a[0]), 4'b0111);
    mode = 2'b00;
    tick();
    check("hold_idx5", int'(q_a[0]), 5);
    $display("[TB] mode change on hold done");

    // Randomised traffic, checked by the per-cycle model comparison.
    for (int i = 0; i < 300; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 9) == 0);
      mode     = 2'($urandom_range(0, 3));
      load_val = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b0; load = 1'b0;
    tick();
    $display("[TB] random traffic done");

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
